multicycle_controller: RTL

- Control FSM for a multicycle RV32I datapath (subset: lw, sw, R-type add/sub/and/or/slt, I-type addi/andi/ori/slti, beq, jal).
- The datapath has one shared memory and one shared ALU; this block sequences them over several cycles per instruction.
- Sits beside the datapath and consumes the instruction fields latched in the instruction register plus the ALU Zero flag.
- Handles a memory-ready handshake and flags unsupported opcodes.

---
 rtl/multicycle_controller.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I datapath sharing one memory and one ALU.
// Sequences fetch/decode/execute/writeback and flags unsupported opcodes.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_ILLEGAL  = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;
  logic [2:0] funct_alu;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
    illegal_d = illegal_q | (state_d == S_ILLEGAL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Only the R-type subtract uses funct7b5; addi with instr[30] set stays an add.
  always_comb begin
    funct_alu = ALU_ADD;
    case (funct3)
      3'b000:  funct_alu = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUControl    = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = MemReady;
        pc_write_raw = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = funct_alu;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = funct_alu;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_BEQ: begin
        ALUSrcA      = 2'b10;
        ALUControl   = ALU_SUB;
        pc_write_raw = Zero;
      end
      S_JAL: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pc_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Write strobes are cut while reset is held so an abandoned instruction cannot commit.
  assign PCWrite  = pc_write_raw  & ~reset;
  assign MemWrite = mem_write_raw & ~reset;
  assign IRWrite  = ir_write_raw  & ~reset;
  assign RegWrite = reg_write_raw & ~reset;
  assign Illegal  = illegal_q;
  assign State    = state_q;

endmodule
